// File: rtl/instr_encoder_pkg.sv
// Shared types for the RV32I field encoder: formats, opcodes, FSM states.
// encode() packs decoded fields into a 32-bit instruction word.
package instr_encoder_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } instr_fmt_t;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic [31:0] encode(
      input logic [2:0]  fmt,
      input logic [6:0]  opc,
      input logic [2:0]  f3,
      input logic [6:0]  f7,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [31:0] imm
   );
      logic [31:0] w;
      w = '0;
      case (instr_fmt_t'(fmt))
         FMT_R: w = {f7, rs2, rs1, f3, rd, opc};
         FMT_I: w = {imm[11:0], rs1, f3, rd, opc};
         FMT_S: w = {imm[11:5], rs2, rs1, f3,
                     imm[4:0], opc};
         FMT_B: w = {imm[12], imm[10:5], rs2, rs1,
                     f3, imm[4:1], imm[11], opc};
         FMT_U: w = {imm[31:12], rd, opc};
         FMT_J: w = {imm[20], imm[10:1], imm[11],
                     imm[19:12], rd, opc};
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// sync_fifo: power-of-two synchronous FIFO, head word shown combinationally.
// Ports: wr_en/wr_data, rd_en/rd_data, full, empty, count (occupancy).
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I field bundles into words and streams them to imem.
// Ports: in_* field handshake, imem_* write port, done pulse, sticky err.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int                DEPTH     = 4,
   parameter int                ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              imem_we,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              done,
   output logic              err
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t          state;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [31:0]     head;
   logic [31:0]     word;
   logic            legal;
   logic            accept;
   logic            enq;
   logic            deq;
   logic            drains;

   assign legal  = (in_fmt <= 3'd5);
   assign accept = in_valid && in_ready;
   assign enq    = accept && legal;
   assign deq    = imem_we && imem_ready;
   assign word   = encode(in_fmt, in_opcode, in_funct3,
                          in_funct7, in_rd, in_rs1,
                          in_rs2, in_imm);

   // FIFO will be empty after this edge: lets done
   // follow the final write by exactly one cycle.
   assign drains = !enq &&
                   ((fifo_count == '0) ||
                    (fifo_count == CW'(1) && deq));

   assign in_ready   = (state == ST_LOAD) && !fifo_full;
   assign imem_we    = !fifo_empty;
   assign imem_wdata = imem_we ? head : '0;
   assign done       = (state == ST_DONE);

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (enq),
      .wr_data (word),
      .rd_en   (deq),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_LOAD;
         imem_addr <= BASE_ADDR;
         err       <= 1'b0;
      end else begin
         unique case (state)
            ST_LOAD: begin
               if (accept && in_last)
                  state <= drains ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
               if (drains) state <= ST_DONE;
            end
            ST_DONE: state <= ST_LOAD;
            default: state <= ST_LOAD;
         endcase

         if (state == ST_DONE)
            imem_addr <= BASE_ADDR;
         else if (deq)
            imem_addr <= imem_addr + 1'b1;

         if (state == ST_DONE)
            err <= 1'b0;
         else if (accept && !legal)
            err <= 1'b1;
      end
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder and program loader. Accepts decoded instruction fields (format, opcode, funct3/funct7, register addresses, immediate) over a valid/ready handshake. It packs each instruction into a 32-bit word, buffers it in a small FIFO, and writes the words to consecutive instruction-memory addresses. It sits in front of the pipelined core's instruction memory, on the side opposite the decoder: testbenches and boot logic use it to build programs from fields instead of hand-written hex.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_W, 10, imem word-address width
- BASE_ADDR, 0, first write address of each program
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_opcode  in  7  opcode[6:0]
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_rd / in_rs1 / in_rs2  in  5 each  register addresses
- in_imm  in  32  immediate, already sign-extended, byte offset for B/J
- in_last  in  1  bundle is the final instruction of the program
- imem_we  out  1  write request; word at FIFO head
- imem_ready  in  1  memory accepts the write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- done  out  1  one-cycle pulse when the program is fully written
- err  out  1  sticky; an illegal format was seen in the current program

## Operation
- Input transfer happens on `in_valid && in_ready`. Output transfer happens on `imem_we && imem_ready`.
- Encoding, with fields listed MSB→LSB:
  - R: funct7, rs2, rs1, funct3, rd, opcode
  - I: imm[11:0], rs1, funct3, rd, opcode
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode
  - U: imm[31:12], rd, opcode
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode
  - Unused immediate bits are ignored, with no range check.
- Illegal fmt: the bundle is accepted and no word is enqueued. `err` sets. `in_last` on an illegal bundle still ends the program.
- FSM states:
  - LOAD: `in_ready = !fifo_full`. Accepting a bundle with `in_last` → DRAIN.
  - DRAIN: `in_ready = 0`. When the FIFO is empty and no write is pending → DONE.
  - DONE: `done = 1` for one cycle; `imem_addr` resets to BASE_ADDR and `err` clears; → LOAD.
- Address counter: increments by 1 per output transfer and wraps modulo 2^ADDR_W silently.
- Enqueue and dequeue in the same cycle are legal; occupancy is unchanged.
- Reset mid-operation: the FIFO is flushed, state → LOAD, and pending words are lost.

## Timing
- Reset values: `in_ready` = 1, `imem_we` = 0, `imem_addr` = BASE_ADDR, `imem_wdata` = 0, `done` = 0, `err` = 0.
- Bundle accepted at edge N → `imem_we` = 1 with its word from cycle N+1 (1-cycle latency when the FIFO was empty).
- While `imem_we && !imem_ready`, `imem_addr` and `imem_wdata` are held stable.
- `in_ready` is combinational from state and FIFO occupancy only; it never depends on `in_valid`.
- A full FIFO deasserts `in_ready` even if a dequeue occurs that cycle.
- `done` pulses the cycle after the final write transfer (DRAIN→DONE), or the cycle after the last accept if nothing remains.
- `err` is visible the cycle after the illegal accept.

## Structure
- The shared package holds:
  - the `instr_fmt_t` enum (R, I, S, B, U, J)
  - RV32I opcode localparams (OP 0x33, OP_IMM 0x13, LOAD 0x03, STORE 0x23, BRANCH 0x63, JAL 0x6F, JALR 0x67, LUI 0x37, AUIPC 0x17, SYSTEM 0x73)
  - the FSM state enum
- Sub-module `sync_fifo` (DEPTH, WIDTH=32) provides the buffer. The encode function is combinational logic inside this block.

## Test plan
- Encode the following back to back, with `imem_ready` = 1:
  - addi x1,x0,5 (I, 0x13) → addr 0 `imem_wdata` 0x00500093
  - add x3,x1,x2 (R, 0x33) → addr 1 0x002081B3
- Encode sw x2,8(x1) (S, funct3 2) → 0x0020A423. Encode beq x1,x2,imm −4 → 0xFE208EE3. Encode jal x1,8 → 0x008000EF.
- Backpressure: hold `imem_ready` = 0 for 8 cycles while sending 6 bundles with DEPTH=4. Required: `in_ready` drops after 4 accepts, `imem_addr` = 0 and `imem_wdata` stay stable, and all 6 words land at addrs 0–5 in order.
- Send 3 bundles with the third carrying `in_last`. Required: `in_ready` = 0 in DRAIN, a single-cycle `done` after the addr-2 write, and the next program starts at BASE_ADDR.
- Send a bundle with fmt = 6 between two legal bundles. Required: `err` = 1 the next cycle, the legal words go to addrs 0 and 1, and `err` clears after `done`.
- With ADDR_W = 2, 5 bundles write addrs 0,1,2,3,0. Asserting `rst_n` low with 2 words queued gives reset values and no further `imem_we`.
